// File: rtl/bp_common_pkg.sv
// Shared backend constants.
//   reg_addr_width_gp : architectural register address width.
package bp_common_pkg;

    localparam int reg_addr_width_gp = 5;

endpackage

// File: rtl/bp_be_fifo_2w1r.sv
// Circular buffer that accepts up to two writes and performs one read per cycle.
//   clk_i, reset_n_i : clock and asynchronous active-low reset
//   enq_n_i          : number of writes this cycle (0..2), data0 is older than data1
//   enq_data0_i/1_i  : write data, packed in order (data1 is used only when enq_n_i==2)
//   deq_i            : pop the head entry (ignored when empty)
//   deq_data_o       : head entry, buf[rptr]
//   count_o          : occupancy
// Writes beyond the free space are dropped, so live entries are never overwritten.
module bp_be_fifo_2w1r #(
    parameter int els_p   = 4,
    parameter int width_p = 5
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic [1:0]                 enq_n_i,
    input  logic [width_p-1:0]         enq_data0_i,
    input  logic [width_p-1:0]         enq_data1_i,
    input  logic                       deq_i,
    output logic [width_p-1:0]         deq_data_o,
    output logic [$clog2(els_p+1)-1:0] count_o
);

    localparam int ptr_w = $clog2(els_p);
    localparam int cnt_w = $clog2(els_p+1);

    logic [width_p-1:0] mem [els_p];
    logic [ptr_w-1:0]   rptr, wptr, wptr_p1;
    logic [cnt_w-1:0]   count, free;
    logic [1:0]         acc;
    logic               deq_eff;

    // Free space is taken before this cycle's pop, which keeps the slot being
    // read untouched even when the buffer is full.
    always_comb begin
        free    = cnt_w'(els_p) - count;
        deq_eff = deq_i && (count != '0);
        wptr_p1 = wptr + ptr_w'(1);
        if (free == '0)
            acc = 2'd0;
        else if (free == cnt_w'(1))
            acc = (enq_n_i != 2'd0) ? 2'd1 : 2'd0;
        else
            acc = enq_n_i;
    end

    // els_p is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            wptr  <= wptr + ptr_w'(acc);
            rptr  <= rptr + ptr_w'(deq_eff);
            count <= count + cnt_w'(acc) - cnt_w'(deq_eff);
        end
    end

    always_ff @(posedge clk_i) begin
        if (acc != 2'd0) mem[wptr]    <= enq_data0_i;
        if (acc == 2'd2) mem[wptr_p1] <= enq_data1_i;
    end

    assign deq_data_o = mem[rptr];
    assign count_o    = count;

endmodule

// File: rtl/bp_be_scoreboard_clear_queue.sv
// Serialises up to two register-release events per cycle onto the scoreboard's
// single clear port, in order, with an empty-queue bypass.
//   clk_i, reset_n_i          : clock and asynchronous active-low reset
//   clear0_v_i, clear0_rd_i   : slot-0 release (older)
//   clear1_v_i, clear1_rd_i   : slot-1 release (younger)
//   ready_o                   : two events can be absorbed this cycle
//   clear_v_o, clear_rd_o     : to scoreboard clear port
//   count_o                   : occupancy, debug/perf
module bp_be_scoreboard_clear_queue
    import bp_common_pkg::*;
#(
    parameter int els_p            = 4,
    parameter int reg_addr_width_p = reg_addr_width_gp
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic                        clear0_v_i,
    input  logic [reg_addr_width_p-1:0] clear0_rd_i,
    input  logic                        clear1_v_i,
    input  logic [reg_addr_width_p-1:0] clear1_rd_i,
    output logic                        ready_o,
    output logic                        clear_v_o,
    output logic [reg_addr_width_p-1:0] clear_rd_o,
    output logic [$clog2(els_p+1)-1:0]  count_o
);

    localparam int cnt_w = $clog2(els_p+1);

    logic [cnt_w-1:0]            fifo_count;
    logic [reg_addr_width_p-1:0] fifo_data;
    logic [reg_addr_width_p-1:0] enq_d0, enq_d1;
    logic [1:0]                  enq_n;
    logic                        empty;

    assign empty = (fifo_count == '0);

    // When empty, the oldest valid event bypasses the buffer and only the
    // slot-1 event of a pair is stored. Otherwise every valid event queues
    // behind existing entries, compacted so data0 is always the older one.
    always_comb begin
        enq_n  = 2'd0;
        enq_d0 = clear0_rd_i;
        enq_d1 = clear1_rd_i;
        if (empty) begin
            if (clear0_v_i && clear1_v_i) begin
                enq_n  = 2'd1;
                enq_d0 = clear1_rd_i;
            end
        end else begin
            if (clear0_v_i && clear1_v_i)
                enq_n = 2'd2;
            else if (clear0_v_i)
                enq_n = 2'd1;
            else if (clear1_v_i) begin
                enq_n  = 2'd1;
                enq_d0 = clear1_rd_i;
            end
        end
    end

    bp_be_fifo_2w1r #(
        .els_p   (els_p),
        .width_p (reg_addr_width_p)
    ) fifo (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .enq_n_i     (enq_n),
        .enq_data0_i (enq_d0),
        .enq_data1_i (enq_d1),
        .deq_i       (!empty),
        .deq_data_o  (fifo_data),
        .count_o     (fifo_count)
    );

    // Gated by reset so a mid-stream reset silences the bypass path at once.
    always_comb begin
        clear_v_o  = 1'b0;
        clear_rd_o = '0;
        if (reset_n_i) begin
            if (empty) begin
                clear_v_o  = clear0_v_i | clear1_v_i;
                clear_rd_o = clear0_v_i ? clear0_rd_i : clear1_rd_i;
            end else begin
                clear_v_o  = 1'b1;
                clear_rd_o = fifo_data;
            end
        end
    end

    // Registered-count only: no combinational path from the inputs.
    assign ready_o = (fifo_count <= cnt_w'(els_p-2));
    assign count_o = fifo_count;

    // Upstream must hold valids low while ready_o is low. Non-fatal so the
    // drop behaviour in the buffer remains observable after a violation.
    always @(posedge clk_i) begin
        if (reset_n_i)
            assert (ready_o || !(clear0_v_i || clear1_v_i))
                else $warning("clear queue: release injected while not ready");
    end

endmodule

// File: tb/tb_bp_be_scoreboard_clear_queue.sv
module tb_bp_be_scoreboard_clear_queue;

    logic       clk_i = 1'b0;
    logic       reset_n_i;
    logic       clear0_v_i, clear1_v_i;
    logic [4:0] clear0_rd_i, clear1_rd_i;
    logic       ready_o, clear_v_o;
    logic [4:0] clear_rd_o;
    logic [2:0] count_o;

    int checks = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    bp_be_scoreboard_clear_queue #(.els_p(4), .reg_addr_width_p(5)) dut (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .clear0_v_i  (clear0_v_i),
        .clear0_rd_i (clear0_rd_i),
        .clear1_v_i  (clear1_v_i),
        .clear1_rd_i (clear1_rd_i),
        .ready_o     (ready_o),
        .clear_v_o   (clear_v_o),
        .clear_rd_o  (clear_rd_o),
        .count_o     (count_o)
    );

    typedef struct {
        logic       v0;
        logic [4:0] rd0;
        logic       v1;
        logic [4:0] rd1;
        logic       ev;
        logic [4:0] erd;
        logic [2:0] ecnt;
        logic       erdy;
    } vec_t;

    vec_t vt [16];

    function automatic vec_t mk(logic v0, int rd0, logic v1, int rd1,
                                logic ev, int erd, int ecnt, logic erdy);
        vec_t r;
        r.v0 = v0; r.rd0 = 5'(rd0); r.v1 = v1; r.rd1 = 5'(rd1);
        r.ev = ev; r.erd = 5'(erd); r.ecnt = 3'(ecnt); r.erdy = erdy;
        return r;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v0, input int rd0, input logic v1, input int rd1);
        clear0_v_i = v0; clear0_rd_i = 5'(rd0);
        clear1_v_i = v1; clear1_rd_i = 5'(rd1);
    endtask

    initial begin
        // Outputs are checked at the negedge, before the edge that consumes the inputs.
        vt[0]  = mk(0, 0,  0, 0,  0, 0,  0, 1);  // idle
        vt[1]  = mk(1, 7,  0, 0,  1, 7,  0, 1);  // lone slot0 bypass
        vt[2]  = mk(0, 0,  0, 0,  0, 0,  0, 1);
        vt[3]  = mk(1, 3,  1, 9,  1, 3,  0, 1);  // pair: 3 bypassed
        vt[4]  = mk(0, 0,  0, 0,  1, 9,  1, 1);  // 9 from buffer
        vt[5]  = mk(0, 0,  0, 0,  0, 0,  0, 1);
        vt[6]  = mk(0, 0,  1, 12, 1, 12, 0, 1);  // lone slot1 bypass
        vt[7]  = mk(0, 0,  0, 0,  0, 0,  0, 1);
        vt[8]  = mk(1, 1,  1, 2,  1, 1,  0, 1);  // sustained pairs
        vt[9]  = mk(1, 3,  1, 4,  1, 2,  1, 1);
        vt[10] = mk(1, 5,  1, 6,  1, 3,  2, 1);
        vt[11] = mk(1, 20, 1, 21, 1, 4,  3, 0);  // violation: only 20 fits
        vt[12] = mk(0, 0,  0, 0,  1, 5,  3, 0);
        vt[13] = mk(0, 0,  0, 0,  1, 6,  2, 1);  // wrapped read
        vt[14] = mk(0, 0,  0, 0,  1, 20, 1, 1);
        vt[15] = mk(0, 0,  0, 0,  0, 0,  0, 1);

        reset_n_i = 1'b0;
        drive(0, 0, 0, 0);
        #1;
        chk("reset_clear_v", int'(clear_v_o), 0);
        chk("reset_count",   int'(count_o),   0);
        chk("reset_ready",   int'(ready_o),   1);
        @(negedge clk_i);
        reset_n_i = 1'b1;

        for (int i = 0; i < 16; i++) begin
            @(posedge clk_i); #1;
            drive(vt[i].v0, int'(vt[i].rd0), vt[i].v1, int'(vt[i].rd1));
            @(negedge clk_i);
            chk($sformatf("v%0d_clear_v", i), int'(clear_v_o), int'(vt[i].ev));
            if (vt[i].ev)
                chk($sformatf("v%0d_clear_rd", i), int'(clear_rd_o), int'(vt[i].erd));
            chk($sformatf("v%0d_count", i), int'(count_o), int'(vt[i].ecnt));
            chk($sformatf("v%0d_ready", i), int'(ready_o), int'(vt[i].erdy));
        end

        // Fill to count=3, then reset mid-stream with inputs still active.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i); #1;
            drive(1, 2*i+1, 1, 2*i+2);
        end
        @(posedge clk_i); #1;
        chk("pre_reset_count", int'(count_o), 3);
        drive(1, 8, 0, 0);
        reset_n_i = 1'b0;
        #1;
        chk("midreset_clear_v", int'(clear_v_o), 0);
        chk("midreset_count",   int'(count_o),   0);
        chk("midreset_ready",   int'(ready_o),   1);
        @(negedge clk_i);
        drive(0, 0, 0, 0);
        reset_n_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk($sformatf("post_reset%0d_clear_v", i), int'(clear_v_o), 0);
            chk($sformatf("post_reset%0d_count", i),   int'(count_o),   0);
        end

        // Bypass still works after the reset.
        @(posedge clk_i); #1;
        drive(1, 5, 0, 0);
        @(negedge clk_i);
        chk("after_reset_clear_v",  int'(clear_v_o),  1);
        chk("after_reset_clear_rd", int'(clear_rd_o), 5);
        @(posedge clk_i); #1;
        drive(0, 0, 0, 0);
        @(negedge clk_i);
        chk("after_reset_idle", int'(clear_v_o), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
